postproc_pipe: RTL and testbench
================================

Name: postproc_pipe

Overview:
- Parametrised successor to the fixed 64-bit bias/activation path between the systolic array and SRAM.
- Takes LANES signed accumulator lanes from the array and, per lane, adds bias, applies a selectable activation, requantizes by an arithmetic right shift, and saturates to OUT_W.
- Runs as a counted job of num_vec vectors, with valid/ready backpressure on both sides.
- Sits between systolic_array outputs and the SRAM/AHB writeback path.

Parameters:
- LANES, 8, number of parallel lanes
- IN_W, 16, signed accumulator/bias width per lane
- OUT_W, 8, signed output width per lane
- CNT_W, 8, width of the vector counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle job start pulse
- num_vec  in  CNT_W  vectors in the job
- mode  in  3  activation select
- shift  in  4  requantization right-shift amount
- bias  in  LANES*IN_W  per-lane signed bias; lane i at [i*IN_W +: IN_W]
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts the input vector
- in_data  in  LANES*IN_W  accumulator vector; lane packing same as bias
- out_valid  out  1  output vector valid
- out_ready  in  1  consumer accepts the output vector
- out_data  out  LANES*OUT_W  saturated result; lane i at [i*OUT_W +: OUT_W]
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- sat_flag  out  1  sticky: some lane saturated during the current job

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE; both pipeline stages are invalid; counters are 0. Outputs: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, sat_flag=0. A reset mid-job discards all in-flight data.
- FSM states:
  - IDLE, on start with num_vec!=0: latch mode, shift, bias and num_vec; clear sat_flag and both counters; go to RUN.
  - IDLE, on start with num_vec==0: stay in IDLE; assert done for one cycle on the next cycle.
  - RUN: accepts inputs. When in_cnt reaches num_vec, go to DRAIN.
  - DRAIN: no inputs accepted. When out_cnt reaches num_vec, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE. A start pulse received while busy is ignored.
- Input handshake: transfer occurs when in_valid && in_ready.
  - in_ready = (state==RUN) && (in_cnt<num_vec) && (!s1_v || s1_adv).
  - in_ready has no combinational dependence on in_valid.
- Pipeline, two registered stages:
  - S1: bias add + activation.
  - S2: shift + saturate; drives out_data and out_valid.
  - Latency is 2 cycles from input transfer to out_valid when out_ready stays high; throughput is 1 vector/cycle.
- Advance rules:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = s2_adv.
  - With out_ready=0, out_data and out_valid hold stable, and S1 holds once S2 is full.
  - No data is ever dropped or duplicated.
- Per-lane arithmetic (signed):
  - sum = sext(in) + sext(bias), computed at IN_W+1 bits.
  - mode 0: identity.
  - mode 1: ReLU; sum<0 gives 0.
  - mode 2: leaky; sum<0 gives sum>>>3, sum>=0 passes unchanged.
  - mode 3: clamp to [0, 2^(OUT_W-1)-1] before the shift.
  - modes 4-7: identity.
  - Requantize: q = act>>>shift (arithmetic shift, rounds toward -inf).
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any lane clipping sets sat_flag.
- Counters:
  - in_cnt increments per input transfer; out_cnt increments per output transfer.
  - Neither wraps within a job, because transfers stop at num_vec.
- Config inputs are ignored while busy; only the values latched at start apply.

Test Plan:
- Basic ReLU: LANES=8, num_vec=1, mode=1, shift=0, bias=0; lanes in=[5,-5,127,200,-1,0,1,-200], out_ready=1 -> out_valid 2 cycles after input transfer; out=[5,0,127,127,0,0,1,0]; sat_flag=1; done pulses 1 cycle after out transfer.
- Bias + leaky + shift: mode=2, shift=1, bias=-40 on all lanes, in=16 -> sum=-24, leaky=-3, >>>1 gives -2 on every lane; sat_flag=0.
- Backpressure streaming: num_vec=4, in_valid=1 continuously, out_ready toggled 1,0,0,1,1,1,... -> exactly 4 outputs in input order; out_data stable while out_ready=0; in_ready=0 after the 4th input; done exactly once.
- Zero-length job and ignored start: start with num_vec=0 -> done=1 next cycle, busy stays 0. A second start during a 3-vector job -> ignored; the job completes with exactly 3 outputs.
- Saturation bound: mode=0, shift=0, in=-32768, bias=-1 -> sum=-32769 (no IN_W wrap); out=-128; sat_flag=1. sat_flag clears on the next start.
- Reset mid-job: assert rst during DRAIN with S2 full -> out_valid, busy and done drop immediately. After release, a new job runs cleanly with no stale output.

Source files
------------

// File: rtl/postproc_pipe.sv
// Per-lane bias add, activation, requantize and saturate over a counted job; 2-cycle latency, 1 vector/cycle.
// Valid/ready on both sides: a stalled consumer freezes S2, then S1, then drops in_ready.
module postproc_pipe #(
  parameter int LANES = 8,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
  input  logic [2:0]             mode,
  input  logic [3:0]             shift,
  input  logic [LANES*IN_W-1:0]  bias,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag
);

  localparam int AW = IN_W + 1;
  localparam logic signed [AW-1:0] A_MAX = AW'(2**(OUT_W-1) - 1);
  localparam logic signed [AW-1:0] A_MIN = AW'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             mode_q;
  logic [3:0]             shift_q;
  logic [LANES*IN_W-1:0]  bias_q;
  logic [CNT_W-1:0]       num_q, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic                   s1_v_q, s2_v_q, sat_q, zdone_q;
  logic [LANES*AW-1:0]    s1_dat_q;
  logic [LANES*OUT_W-1:0] s2_dat_q;

  logic                   s1_adv, s2_adv, s1_ld, in_fire, out_fire, start_ok;
  logic [LANES*AW-1:0]    act_w;
  logic [LANES*OUT_W-1:0] sat_w;
  logic [LANES-1:0]       clip_w;

  function automatic logic signed [AW-1:0] activate(input logic [IN_W-1:0] a,
                                                    input logic [IN_W-1:0] b,
                                                    input logic [2:0]      m);
    logic signed [AW-1:0] s;
    logic signed [AW-1:0] r;
    s = {a[IN_W-1], a} + {b[IN_W-1], b};
    r = s;
    case (m)
      3'd1: if (s[AW-1]) r = '0;
      3'd2: if (s[AW-1]) r = s >>> 3;
      3'd3: begin
        if (s[AW-1])        r = '0;
        else if (s > A_MAX) r = A_MAX;
      end
      default: r = s;
    endcase
    return r;
  endfunction

  // MSB of the result flags a clipped lane
  function automatic logic [OUT_W:0] requant(input logic [AW-1:0] a, input logic [3:0] sh);
    logic signed [AW-1:0] q;
    logic [OUT_W:0]       r;
    q = $signed(a) >>> sh;
    if (q > A_MAX)      r = {1'b1, A_MAX[OUT_W-1:0]};
    else if (q < A_MIN) r = {1'b1, A_MIN[OUT_W-1:0]};
    else                r = {1'b0, q[OUT_W-1:0]};
    return r;
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign act_w[i*AW +: AW] = activate(in_data[i*IN_W +: IN_W], bias_q[i*IN_W +: IN_W], mode_q);
    assign {clip_w[i], sat_w[i*OUT_W +: OUT_W]} = requant(s1_dat_q[i*AW +: AW], shift_q);
  end

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = s2_adv;
  assign s1_ld    = !s1_v_q || s1_adv;
  assign in_ready = (state_q == S_RUN) && (in_cnt_q < num_q) && s1_ld;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_v_q && out_ready;
  assign start_ok = start && (state_q == S_IDLE) && (num_vec != '0);

  assign in_cnt_d  = start_ok ? '0 : in_cnt_q + CNT_W'(in_fire);
  assign out_cnt_d = start_ok ? '0 : out_cnt_q + CNT_W'(out_fire);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (in_cnt_d == num_q) state_d = S_DRAIN;
      S_DRAIN: if (out_cnt_d == num_q) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN) || zdone_q;
    out_valid = s2_v_q;
    out_data  = s2_dat_q;
    sat_flag  = sat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      shift_q   <= '0;
      bias_q    <= '0;
      num_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      s1_v_q    <= 1'b0;
      s1_dat_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_dat_q  <= '0;
      sat_q     <= 1'b0;
      zdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      zdone_q   <= start && (state_q == S_IDLE) && (num_vec == '0);
      if (start_ok) begin
        mode_q  <= mode;
        shift_q <= shift;
        bias_q  <= bias;
        num_q   <= num_vec;
        sat_q   <= 1'b0;
      end else if (s2_adv && s1_v_q && (|clip_w)) begin
        sat_q   <= 1'b1;
      end
      if (s1_ld) begin
        s1_v_q <= in_fire;
        if (in_fire) s1_dat_q <= act_w;
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_dat_q <= sat_w;
      end
    end
  end

endmodule

// File: tb/tb_postproc_pipe.sv
// Bench for postproc_pipe: directed jobs plus random jobs scored against an integer-arithmetic model.
module tb_postproc_pipe;
  localparam int LANES = 8;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int CNT_W = 8;
  localparam int OMAX  = 2**(OUT_W-1) - 1;
  localparam int OMIN  = -(2**(OUT_W-1));

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [CNT_W-1:0]       num_vec = '0;
  logic [2:0]             mode = '0;
  logic [3:0]             shift = '0;
  logic [LANES*IN_W-1:0]  bias = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   busy, done, sat_flag;

  postproc_pipe #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .mode(mode), .shift(shift),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [LANES*IN_W-1:0]  vecs [0:63];
  logic [LANES*OUT_W-1:0] last_out;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {any_lane_clipped, packed_outputs}
  function automatic logic [LANES*OUT_W:0] model(input logic [LANES*IN_W-1:0] x,
                                                 input logic [LANES*IN_W-1:0] b,
                                                 input logic [2:0] m, input logic [3:0] sh);
    logic [LANES*OUT_W-1:0] o;
    bit clip;
    o = '0;
    clip = 0;
    for (int i = 0; i < LANES; i++) begin
      int s, q;
      s = int'($signed(x[i*IN_W +: IN_W])) + int'($signed(b[i*IN_W +: IN_W]));
      case (m)
        3'd1: if (s < 0) s = 0;
        3'd2: if (s < 0) s = s >>> 3;
        3'd3: s = (s < 0) ? 0 : ((s > OMAX) ? OMAX : s);
        default: ;
      endcase
      q = s >>> sh;
      if (q > OMAX) begin q = OMAX; clip = 1; end
      else if (q < OMIN) begin q = OMIN; clip = 1; end
      o[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
    end
    return {clip, o};
  endfunction

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) vecs[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // rdy_mode: 0 always ready, 1 fixed stall pattern, 2 random
  task automatic run_job(input int n, input logic [2:0] m, input logic [3:0] sh,
                         input logic [LANES*IN_W-1:0] b, input int rdy_mode,
                         input bit rand_valid, input bit extra_start);
    logic [LANES*OUT_W-1:0] exp_q [$];
    logic [LANES*OUT_W:0]   r;
    logic [LANES*OUT_W-1:0] prev_dat;
    logic [5:0]             pat;
    bit sat_exp, prev_stall;
    int sent, got, cyc, post, done_cnt, t_first_in, t_first_ov, t_last, t_done;
    sat_exp = 0; prev_stall = 0; prev_dat = '0; pat = 6'b111001;
    sent = 0; got = 0; cyc = 0; post = 0; done_cnt = 0;
    t_first_in = -1; t_first_ov = -1; t_last = -1; t_done = -1;

    @(negedge clk);
    start = 1'b1; num_vec = CNT_W'(n); mode = m; shift = sh; bias = b;
    @(negedge clk);
    start = 1'b0; num_vec = CNT_W'($urandom); mode = 3'($urandom); shift = 4'($urandom);
    bias = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("busy_start", busy, 1);
    check("sat_clear", sat_flag, 0);

    while (cyc < 1000) begin
      in_valid = (sent < n) && (!rand_valid || $urandom_range(0, 3) != 0);
      in_data  = (sent < n) ? vecs[sent] : '0;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 6];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (extra_start && cyc == 2) begin
        start = 1'b1; num_vec = 8'd7;
      end
      #1;
      if (prev_stall) begin
        check("hold_vld", out_valid, 1);
        check("hold_dat", out_data, prev_dat);
      end
      if (done) begin done_cnt++; t_done = cyc; end
      if (out_valid && t_first_ov < 0) t_first_ov = cyc;
      if (sent == n) check("in_ready_end", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("out_data", out_data, exp_q.pop_front());
        got++; t_last = cyc; last_out = out_data;
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      if (in_valid && in_ready) begin
        r = model(vecs[sent], b, m, sh);
        exp_q.push_back(r[LANES*OUT_W-1:0]);
        sat_exp |= r[LANES*OUT_W];
        if (t_first_in < 0) t_first_in = cyc;
        sent++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (got >= n) post++;
      if (post == 4) break;
    end
    in_valid = 1'b0;
    #1;
    check("timeout", cyc < 1000, 1);
    check("n_out", got, n);
    check("done_once", done_cnt, 1);
    check("done_lat", t_done, t_last + 1);
    check("sat_flag", sat_flag, sat_exp);
    check("busy_end", busy, 0);
    check("q_empty", exp_q.size(), 0);
    if (rdy_mode == 0 && !rand_valid) check("latency", t_first_ov - t_first_in, 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tv [LANES];
    int cnt;
    tv = '{5, -5, 127, 200, -1, 0, 1, -200};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat_flag, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic ReLU with one clipping lane
    for (int i = 0; i < LANES; i++) vecs[0][i*IN_W +: IN_W] = 16'(tv[i]);
    run_job(1, 3'd1, 4'd0, '0, 0, 0, 0);
    check("relu_vec", last_out, 64'h00_01_00_00_7F_7F_00_05);
    check("relu_sat", sat_flag, 1);

    // Bias -40, leaky, shift 1
    vecs[0] = {LANES{16'd16}};
    run_job(1, 3'd2, 4'd1, {LANES{16'hFFD8}}, 0, 0, 0);
    check("leaky_vec", last_out, {LANES{8'hFE}});
    check("leaky_sat", sat_flag, 0);

    // Backpressure streaming
    fill_random(4);
    run_job(4, 3'd0, 4'd4, '0, 1, 0, 0);

    // Zero-length job
    @(negedge clk);
    start = 1'b1; num_vec = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zlen_done", done, 1);
    check("zlen_busy", busy, 0);
    @(negedge clk);
    #1;
    check("zlen_done_off", done, 0);
    check("zlen_busy_off", busy, 0);

    // Start while busy is ignored
    fill_random(3);
    run_job(3, 3'd3, 4'd2, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);

    // Saturation at the negative bound, no IN_W wrap
    vecs[0] = {LANES{16'h8000}};
    run_job(1, 3'd0, 4'd0, {LANES{16'hFFFF}}, 0, 0, 0);
    check("sat_vec", last_out, {LANES{8'h80}});
    check("sat_bound", sat_flag, 1);

    // Reset during DRAIN with S2 full
    @(negedge clk);
    start = 1'b1; num_vec = 8'd2; mode = 3'd0; shift = 4'd0; bias = '0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 2; k++) begin
      #1;
      if (in_ready) cnt++;
      @(negedge clk);
      in_data = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_vld", out_valid, 1);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    fill_random(5);
    run_job(5, 3'd1, 4'd3, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);

    // Random jobs
    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      run_job(n, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 9)),
              {$urandom, $urandom, $urandom, $urandom}, 2, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
